// File: rtl/trap_controller_if.sv
// Bundle of exception, interrupt, MRET and CSR signals between the core and the
// machine-mode trap sequencer.
interface trap_controller_if;
  logic        exception_taken;
  logic [31:0] exception_cause;
  logic [31:0] exception_val;
  logic [31:0] exception_pc;
  logic [31:0] next_pc;
  logic        irq_ok;
  logic        irq_software;
  logic        irq_timer;
  logic        irq_external;
  logic        mret;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        trap_redirect;
  logic [31:0] trap_target;
  logic        trap_busy;

  modport slave (
    input  exception_taken, exception_cause, exception_val, exception_pc, next_pc,
    input  irq_ok, irq_software, irq_timer, irq_external, mret,
    input  csr_we, csr_addr, csr_wdata,
    output csr_rdata, csr_hit, trap_redirect, trap_target, trap_busy
  );

  modport master (
    output exception_taken, exception_cause, exception_val, exception_pc, next_pc,
    output irq_ok, irq_software, irq_timer, irq_external, mret,
    output csr_we, csr_addr, csr_wdata,
    input  csr_rdata, csr_hit, trap_redirect, trap_target, trap_busy
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: owns the trap CSRs and issues a registered
// one-cycle PC redirect on trap entry and MRET.
module trap_controller #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  trap_controller_if.slave trap_if
);

  typedef enum logic [1:0] {IDLE = 2'd0, ENTER = 2'd1, RETURN = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] target_q, target_d;
  logic        redirect_q, redirect_d;

  logic [31:0] mip;
  logic [31:0] mip_en;
  logic [31:0] irq_cause;
  logic [31:0] tvec_base;
  logic        idle;
  logic        irq_pend;
  logic        take_exc;
  logic        take_irq;
  logic        take_mret;
  logic        csr_wr;

  assign mip       = {20'b0, trap_if.irq_external, 3'b0, trap_if.irq_timer,
                      3'b0, trap_if.irq_software, 3'b0};
  assign mip_en    = mip & mie_q;
  assign idle      = (state_q == IDLE);
  assign irq_pend  = mstatus_mie_q & trap_if.irq_ok & (|mip_en);
  assign tvec_base = {mtvec_q[31:2], 2'b00};

  // Accept priority: exception, then interrupt, then mret; only while idle.
  assign take_exc  = idle & trap_if.exception_taken;
  assign take_irq  = idle & ~trap_if.exception_taken & irq_pend;
  assign take_mret = idle & ~trap_if.exception_taken & ~irq_pend & trap_if.mret;
  assign csr_wr    = idle & trap_if.csr_we & ~(take_exc | take_irq | take_mret);

  always_comb begin
    irq_cause = 32'h8000_0007;
    if (mip_en[11])     irq_cause = 32'h8000_000B;
    else if (mip_en[3]) irq_cause = 32'h8000_0003;
  end

  always_comb begin
    state_d        = state_q;
    redirect_d     = 1'b0;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    target_d       = target_q;

    case (state_q)
      IDLE: begin
        if (take_exc) begin
          state_d        = ENTER;
          redirect_d     = 1'b1;
          mepc_d         = trap_if.exception_pc & 32'hFFFF_FFFC;
          mcause_d       = trap_if.exception_cause;
          mtval_d        = trap_if.exception_val;
          mstatus_mpie_d = mstatus_mie_q;
          mstatus_mie_d  = 1'b0;
          target_d       = tvec_base;
        end else if (take_irq) begin
          state_d        = ENTER;
          redirect_d     = 1'b1;
          mepc_d         = trap_if.next_pc & 32'hFFFF_FFFC;
          mcause_d       = irq_cause;
          mtval_d        = 32'h0;
          mstatus_mpie_d = mstatus_mie_q;
          mstatus_mie_d  = 1'b0;
          // Vectored mode offsets by 4*cause with the interrupt flag stripped.
          target_d       = (mtvec_q[1:0] == 2'b01) ?
                           tvec_base + {irq_cause[29:0], 2'b00} : tvec_base;
        end else if (take_mret) begin
          state_d        = RETURN;
          redirect_d     = 1'b1;
          mstatus_mie_d  = mstatus_mpie_q;
          mstatus_mpie_d = 1'b1;
          target_d       = mepc_q;
        end
      end
      ENTER, RETURN: state_d = IDLE;
      default:       state_d = IDLE;
    endcase

    if (csr_wr) begin
      case (trap_if.csr_addr)
        12'h300: begin
          mstatus_mie_d  = trap_if.csr_wdata[3];
          mstatus_mpie_d = trap_if.csr_wdata[7];
        end
        12'h304: mie_d    = trap_if.csr_wdata & 32'h0000_0888;
        12'h305: mtvec_d  = trap_if.csr_wdata[1] ? {trap_if.csr_wdata[31:2], 2'b00}
                                                 : trap_if.csr_wdata;
        12'h341: mepc_d   = trap_if.csr_wdata & 32'hFFFF_FFFC;
        12'h342: mcause_d = trap_if.csr_wdata;
        12'h343: mtval_d  = trap_if.csr_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    trap_if.csr_hit   = 1'b1;
    trap_if.csr_rdata = 32'h0;
    case (trap_if.csr_addr)
      12'h300: trap_if.csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0,
                                    mstatus_mie_q, 3'b0};
      12'h304: trap_if.csr_rdata = mie_q;
      12'h305: trap_if.csr_rdata = mtvec_q;
      12'h341: trap_if.csr_rdata = mepc_q;
      12'h342: trap_if.csr_rdata = mcause_q;
      12'h343: trap_if.csr_rdata = mtval_q;
      12'h344: trap_if.csr_rdata = mip;
      default: trap_if.csr_hit   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      redirect_q     <= 1'b0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'h0;
      mtvec_q        <= MTVEC_RESET;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mtval_q        <= 32'h0;
      target_q       <= 32'h0;
    end else begin
      state_q        <= state_d;
      redirect_q     <= redirect_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      target_q       <= target_d;
    end
  end

  assign trap_if.trap_redirect = redirect_q;
  assign trap_if.trap_target   = target_q;
  assign trap_if.trap_busy     = (state_q != IDLE);

endmodule

// File: doc/trap_controller.md
# trap_controller

Machine-mode trap sequencer. It sits downstream of the core's exception detection and consumes its `exception_taken`/cause/value outputs together with the interrupt lines and MRET. It owns the trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause, mtval) and drives a registered PC redirect/flush request into fetch. The CSR file serves all other CSR addresses; this block answers only the addresses listed below.

## Interface
- `MTVEC_RESET`, default 32'h0000_0000: reset value of mtvec (mode bits included).
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `exception_taken`  in  1  exception present on the instruction at the trap boundary.
- `exception_cause`  in  32  mcause code (bit 31 = 0).
- `exception_val`  in  32  value for mtval.
- `exception_pc`  in  32  PC of the faulting instruction.
- `next_pc`  in  32  PC of the next instruction; saved on an interrupt.
- `irq_ok`  in  1  core is at an instruction boundary where an interrupt may be taken.
- `irq_software`, `irq_timer`, `irq_external`  in  1 each  level-sensitive interrupt lines.
- `mret`  in  1  MRET retiring this cycle.
- `csr_we`  in  1  CSR write strobe.
- `csr_addr`  in  12  CSR address.
- `csr_wdata`  in  32  CSR write data, already resolved for set/clear.
- `csr_rdata`  out  32  combinational read of `csr_addr`; 0 for unhandled addresses.
- `csr_hit`  out  1  `csr_addr` is one of this block's CSRs.
- `trap_redirect`  out  1  one-cycle flush-and-redirect pulse.
- `trap_target`  out  32  redirect PC; valid while `trap_redirect`=1.
- `trap_busy`  out  1  sequencer not idle; core stalls issue.

## Operation
- CSRs handled:
  - 0x300 mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - 0x304 mie: bits 3, 7, 11 writable; all others read 0.
  - 0x305 mtvec: WARL; a written mode of 2 or 3 stores 0.
  - 0x341 mepc: write forces [1:0]=0.
  - 0x342 mcause: full 32 bits.
  - 0x343 mtval: full 32 bits.
  - 0x344 mip: read-only; bit3=`irq_software`, bit7=`irq_timer`, bit11=`irq_external`.
- `irq_pend` = mstatus.MIE & `irq_ok` & |(mip & mie).
- Interrupt cause priority: external (0x8000_000B) > software (0x8000_0003) > timer (0x8000_0007).
- States are IDLE, ENTER and RETURN. Requests are accepted only in IDLE, with priority exception > interrupt > mret.
- Trap accept (IDLE->ENTER):
  - mepc <= (exception ? `exception_pc` : `next_pc`) with [1:0] cleared.
  - mcause <= cause.
  - mtval <= exception ? `exception_val` : 0.
  - MPIE <= MIE, MIE <= 0.
  - trap_target <= base for an exception or when mtvec mode=0; base + 4*cause[30:0] for an interrupt when mode=1. base = {mtvec[31:2], 2'b00}.
- MRET accept (IDLE->RETURN): MIE <= MPIE, MPIE <= 1, trap_target <= mepc.
- ENTER->IDLE and RETURN->IDLE occur unconditionally after one cycle.
- `csr_we` is dropped on the accept edge and while `trap_busy`=1; otherwise it is written at the edge.
- `mret` asserted while busy is ignored. The core holds it until the block is idle.
- Arithmetic: vector offset is 32-bit modulo 2^32; wrap is not checked.

## Timing
- Reset: state IDLE; mstatus MIE=MPIE=0; mie, mepc, mcause, mtval = 0; mtvec=`MTVEC_RESET`; `trap_redirect`=0, `trap_target`=0, `trap_busy`=0.
- Accept at edge N. During cycle N+1: `trap_redirect`=1, `trap_busy`=1, and the CSRs already show new values. Both outputs return to 0 in cycle N+2. The earliest next accept is edge N+2.
- Back-to-back: an exception held high through ENTER is re-taken at edge N+2. Its saved state is MIE=0 and MPIE=0.
- `rst` during ENTER or RETURN returns the block to IDLE at that edge, and `trap_redirect` drops the next cycle.
- Exception, interrupt and mret all in the same cycle: only the exception is taken; mret is dropped.
- `csr_rdata` during cycle N+1 reflects the post-trap values.

## Test plan
- Reset, then read all CSRs -> mstatus=0x0000_1800, mtvec=`MTVEC_RESET`, all others 0; outputs 0.
- mtvec=0x100. Exception cause 2, pc 0x204, val 0xDEAD_BEEF -> redirect pulse of exactly one cycle to 0x100; mepc=0x204, mcause=2, mtval=0xDEAD_BEEF; MIE cleared, MPIE = old MIE.
- mtvec=0x101, MIE=1, mie=0x880, `irq_timer` and `irq_external` high with `irq_ok`, next_pc 0x40 -> target 0x12C, mcause=0x8000_000B, mepc=0x40, mtval=0.
- Repeat with MIE=0 or `irq_ok`=0 -> no redirect, busy stays 0.
- After the trap, mret -> target=mepc, MIE=1, MPIE=1. An mret asserted during ENTER is not accepted until IDLE.
- Exception coincident with `csr_we` to mtval -> mtval = `exception_val`. `rst` in ENTER -> IDLE with all CSRs at reset values.
- Write mtvec=0x103 -> reads 0x100; write mepc=0x207 -> reads 0x204.
